// File: rtl/tictactoe_nxn.sv
// N-by-N tic-tac-toe core: valid/ready move entry with occupancy checks, then a
// fixed-latency K-in-a-row scan radiating out from the last placed cell.
module tictactoe_nxn #(
    parameter int N = 3,
    parameter int K = 3,
    localparam int CW = ($clog2(N) > 1) ? $clog2(N) : 1,
    localparam int MW = $clog2(N*N+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              move_valid,
    input  logic [CW-1:0]     move_row,
    input  logic [CW-1:0]     move_col,
    output logic              move_ready,
    output logic              move_ok,
    output logic              move_illegal,
    output logic [1:0]        turn,
    output logic              busy,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic              draw,
    output logic [MW-1:0]     move_count,
    output logic [2*N*N-1:0]  board
);

    localparam int IW = $clog2(N*N);
    localparam logic signed [5:0] NS = 6'(N);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state;
    logic [N*N-1:0][1:0]     cells;
    logic [CW-1:0]           lat_r, lat_c;
    logic [1:0]              mover;

    // scan position: direction, side (0 = +, 1 = -), step within the side
    logic [1:0]              dir;
    logic                    side;
    logic [2:0]              step;
    logic [3:0]              run;
    logic                    alive;
    logic                    win;

    assign move_ready = (state == S_WAIT);
    assign busy       = (state == S_CHECK);
    assign game_over  = (state == S_DONE);
    assign board      = cells;

    logic          mv_oob, mv_legal;
    logic [IW-1:0] mv_idx;

    assign mv_oob = ({1'b0, move_row} >= (CW+1)'(N)) || ({1'b0, move_col} >= (CW+1)'(N));

    always_comb begin
        mv_idx = '0;
        if (!mv_oob)
            mv_idx = IW'(move_row) * IW'(N) + IW'(move_col);
    end

    assign mv_legal = !mv_oob && (cells[mv_idx] == 2'b00);

    logic signed [5:0] sv, dr, dc, dr_s, dc_s, pr, pc;
    logic              in_b, hit, last_step, scan_end, win_nx;
    logic [IW-1:0]     sc_idx;
    logic [3:0]        run_nx;

    always_comb begin
        sv = $signed(6'(step)) + 6'sd1;
        case (dir)
            2'd0:    begin dr = 6'sd0; dc = 6'sd1;  end
            2'd1:    begin dr = 6'sd1; dc = 6'sd0;  end
            2'd2:    begin dr = 6'sd1; dc = 6'sd1;  end
            default: begin dr = 6'sd1; dc = -6'sd1; end
        endcase
        dr_s = side ? -dr : dr;
        dc_s = side ? -dc : dc;
        pr   = $signed(6'(lat_r)) + sv * dr_s;
        pc   = $signed(6'(lat_c)) + sv * dc_s;
        in_b = (pr >= 6'sd0) && (pr < NS) && (pc >= 6'sd0) && (pc < NS);
        sc_idx = '0;
        if (in_b)
            sc_idx = IW'(pr[2:0]) * IW'(N) + IW'(pc[2:0]);
    end

    assign hit       = alive && in_b && (cells[sc_idx] == mover);
    assign run_nx    = run + {3'b000, hit};
    assign last_step = (step == 3'(K-2));
    assign scan_end  = (dir == 2'd3) && side && last_step;
    // run is judged only once both sides of a line have been walked
    assign win_nx    = win || (side && last_step && (run_nx >= 4'(K)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cells        <= '0;
            turn         <= 2'b00;
            winner       <= 2'b00;
            draw         <= 1'b0;
            move_ok      <= 1'b0;
            move_illegal <= 1'b0;
            move_count   <= '0;
            lat_r        <= '0;
            lat_c        <= '0;
            mover        <= 2'b00;
            dir          <= 2'd0;
            side         <= 1'b0;
            step         <= 3'd0;
            run          <= 4'd1;
            alive        <= 1'b1;
            win          <= 1'b0;
        end else begin
            move_ok      <= 1'b0;
            move_illegal <= 1'b0;
            if (start) begin
                state      <= S_WAIT;
                cells      <= '0;
                turn       <= 2'b01;
                winner     <= 2'b00;
                draw       <= 1'b0;
                move_count <= '0;
                dir        <= 2'd0;
                side       <= 1'b0;
                step       <= 3'd0;
                run        <= 4'd1;
                alive      <= 1'b1;
                win        <= 1'b0;
            end else begin
                case (state)
                    S_WAIT: begin
                        if (move_valid) begin
                            if (mv_legal) begin
                                cells[mv_idx] <= turn;
                                move_count    <= move_count + 1'b1;
                                move_ok       <= 1'b1;
                                lat_r         <= move_row;
                                lat_c         <= move_col;
                                mover         <= turn;
                                dir           <= 2'd0;
                                side          <= 1'b0;
                                step          <= 3'd0;
                                run           <= 4'd1;
                                alive         <= 1'b1;
                                win           <= 1'b0;
                                state         <= S_CHECK;
                            end else begin
                                move_illegal  <= 1'b1;
                            end
                        end
                    end
                    S_CHECK: begin
                        win <= win_nx;
                        if (last_step) begin
                            step  <= 3'd0;
                            alive <= 1'b1;
                            if (side) begin
                                side <= 1'b0;
                                dir  <= dir + 2'd1;
                                run  <= 4'd1;
                            end else begin
                                side <= 1'b1;
                                run  <= run_nx;
                            end
                        end else begin
                            step  <= step + 3'd1;
                            alive <= hit;
                            run   <= run_nx;
                        end
                        if (scan_end) begin
                            if (win_nx) begin
                                winner <= mover;
                                state  <= S_DONE;
                            end else if (move_count == MW'(N*N)) begin
                                draw   <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                turn   <= (turn == 2'b01) ? 2'b10 : 2'b01;
                                state  <= S_WAIT;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tictactoe_nxn.sv
// Three cores (3x3 K=3, 5x5 K=4, 5x5 K=5) share one stimulus stream and are
// compared every cycle against a move-level game model plus literal spot checks.
module tb_tictactoe_nxn;

    logic       clk;
    logic       reset, start, move_valid;
    logic [2:0] move_row, move_col;

    logic       rdy[3], okp[3], ill[3], bsy[3], ovr[3], drw[3];
    logic [1:0] trn[3], wnr[3];
    logic [3:0] cnt0;
    logic [4:0] cnt1, cnt2;
    logic [17:0] brd0;
    logic [49:0] brd1, brd2;
    logic [63:0] cnt_v[3], brd_v[3];

    assign cnt_v[0] = 64'(cnt0);
    assign cnt_v[1] = 64'(cnt1);
    assign cnt_v[2] = 64'(cnt2);
    assign brd_v[0] = 64'(brd0);
    assign brd_v[1] = 64'(brd1);
    assign brd_v[2] = 64'(brd2);

    tictactoe_nxn #(.N(3), .K(3)) u0 (
        .clk(clk), .reset(reset), .start(start), .move_valid(move_valid),
        .move_row(move_row[1:0]), .move_col(move_col[1:0]),
        .move_ready(rdy[0]), .move_ok(okp[0]), .move_illegal(ill[0]), .turn(trn[0]),
        .busy(bsy[0]), .game_over(ovr[0]), .winner(wnr[0]), .draw(drw[0]),
        .move_count(cnt0), .board(brd0));

    tictactoe_nxn #(.N(5), .K(4)) u1 (
        .clk(clk), .reset(reset), .start(start), .move_valid(move_valid),
        .move_row(move_row), .move_col(move_col),
        .move_ready(rdy[1]), .move_ok(okp[1]), .move_illegal(ill[1]), .turn(trn[1]),
        .busy(bsy[1]), .game_over(ovr[1]), .winner(wnr[1]), .draw(drw[1]),
        .move_count(cnt1), .board(brd1));

    tictactoe_nxn #(.N(5), .K(5)) u2 (
        .clk(clk), .reset(reset), .start(start), .move_valid(move_valid),
        .move_row(move_row), .move_col(move_col),
        .move_ready(rdy[2]), .move_ok(okp[2]), .move_illegal(ill[2]), .turn(trn[2]),
        .busy(bsy[2]), .game_over(ovr[2]), .winner(wnr[2]), .draw(drw[2]),
        .move_count(cnt2), .board(brd2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nchk = 0;
    int nerr = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL u%0d.%s: got %0h expected %0h (t=%0t)", i, name, act, exp, $time);
        end
    endtask

    // ---------------- game model: states 0 idle, 1 waiting, 2 scanning, 3 over
    int mn[3]  = '{3, 5, 5};
    int mk[3]  = '{3, 4, 5};
    int mcw[3] = '{2, 3, 3};
    int mst[3], mturn[3], mwin[3], mdraw[3], mcnt[3], mok[3], mill[3], mcd[3], mpend[3];
    int mb[3][8][8];

    function automatic int wins(input int i, input int r, input int c, input int p);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        for (int d = 0; d < 4; d++) begin
            int run;
            run = 1;
            for (int s = -1; s <= 1; s += 2) begin
                int rr, cc;
                rr = r + s * dr[d];
                cc = c + s * dc[d];
                while (rr >= 0 && rr < mn[i] && cc >= 0 && cc < mn[i] && mb[i][rr][cc] == p) begin
                    run++;
                    rr += s * dr[d];
                    cc += s * dc[d];
                end
            end
            if (run >= mk[i]) return 1;
        end
        return 0;
    endfunction

    task automatic clear_board(input int i);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mb[i][r][c] = 0;
    endtask

    task automatic model_step(input int i);
        int r, c, msk;
        msk = (1 << mcw[i]) - 1;
        r = int'(move_row) & msk;
        c = int'(move_col) & msk;
        if (reset) begin
            clear_board(i);
            mst[i] = 0; mturn[i] = 0; mwin[i] = 0; mdraw[i] = 0;
            mcnt[i] = 0; mok[i] = 0; mill[i] = 0; mcd[i] = 0; mpend[i] = 0;
        end else begin
            mok[i] = 0;
            mill[i] = 0;
            if (start) begin
                clear_board(i);
                mcnt[i] = 0; mwin[i] = 0; mdraw[i] = 0; mturn[i] = 1; mst[i] = 1; mcd[i] = 0;
            end else if (mst[i] == 1 && move_valid) begin
                if (r >= mn[i] || c >= mn[i] || mb[i][r][c] != 0) begin
                    mill[i] = 1;
                end else begin
                    mb[i][r][c] = mturn[i];
                    mcnt[i]++;
                    mok[i] = 1;
                    mpend[i] = wins(i, r, c, mturn[i]);
                    mcd[i] = 8 * (mk[i] - 1);
                    mst[i] = 2;
                end
            end else if (mst[i] == 2) begin
                mcd[i]--;
                if (mcd[i] == 0) begin
                    if (mpend[i] != 0) begin
                        mwin[i] = mturn[i];
                        mst[i] = 3;
                    end else if (mcnt[i] == mn[i] * mn[i]) begin
                        mdraw[i] = 1;
                        mst[i] = 3;
                    end else begin
                        mturn[i] = 3 - mturn[i];
                        mst[i] = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [63:0] exp_board(input int i);
        logic [63:0] b;
        b = '0;
        for (int r = 0; r < mn[i]; r++)
            for (int c = 0; c < mn[i]; c++)
                b |= 64'(mb[i][r][c]) << (2 * (r * mn[i] + c));
        return b;
    endfunction

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                chk("move_ready",   i, 64'(rdy[i]), 64'(mst[i] == 1));
                chk("busy",         i, 64'(bsy[i]), 64'(mst[i] == 2));
                chk("game_over",    i, 64'(ovr[i]), 64'(mst[i] == 3));
                chk("move_ok",      i, 64'(okp[i]), 64'(mok[i]));
                chk("move_illegal", i, 64'(ill[i]), 64'(mill[i]));
                chk("turn",         i, 64'(trn[i]), 64'(mturn[i]));
                chk("winner",       i, 64'(wnr[i]), 64'(mwin[i]));
                chk("draw",         i, 64'(drw[i]), 64'(mdraw[i]));
                chk("move_count",   i, cnt_v[i],    64'(mcnt[i]));
                chk("board",        i, brd_v[i],    exp_board(i));
            end
        end
    end

    // ---------------- stimulus
    task automatic play(input int tgt, input int r, input int c);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rdy[tgt] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy[tgt]) chk("ready_wait", tgt, 64'(rdy[tgt]), 64'd1);
        move_row   = 3'(r);
        move_col   = 3'(c);
        move_valid = 1'b1;
        @(posedge clk);
        #1 move_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; move_valid = 1'b0; move_row = '0; move_col = '0;
        @(posedge clk);
        #1 cmp_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 0, 64'(rdy[0]), 64'd0);
        chk("rst_turn",  0, 64'(trn[0]), 64'd0);
        chk("rst_board", 0, brd_v[0],    64'd0);
        chk("rst_count", 0, cnt_v[0],    64'd0);
        reset = 1'b0;

        pulse_start();
        @(negedge clk);
        chk("start_ready", 0, 64'(rdy[0]), 64'd1);
        chk("start_turn",  0, 64'(trn[0]), 64'd1);
        chk("start_board", 0, brd_v[0],    64'd0);

        // row win on the 3x3 core
        play(0, 0, 0); play(0, 1, 0); play(0, 0, 1); play(0, 1, 1); play(0, 0, 2);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("row_busy15",  0, 64'(bsy[0]), 64'd1);
        chk("row_win15",   0, 64'(wnr[0]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("row_winner",  0, 64'(wnr[0]), 64'd1);
        chk("row_over",    0, 64'(ovr[0]), 64'd1);
        chk("row_count",   0, cnt_v[0],    64'd5);
        chk("row_ready",   0, 64'(rdy[0]), 64'd0);
        move_row = 3'd2; move_col = 3'd2; move_valid = 1'b1;
        @(posedge clk);
        #1 move_valid = 1'b0;
        @(negedge clk);
        chk("done_ok",     0, 64'(okp[0]), 64'd0);
        chk("done_count",  0, cnt_v[0],    64'd5);
        chk("done_board",  0, brd_v[0],    64'h295);

        // illegal moves
        pulse_start();
        play(0, 1, 1);
        play(0, 1, 1);
        @(negedge clk);
        chk("occ_illegal", 0, 64'(ill[0]), 64'd1);
        chk("occ_ok",      0, 64'(okp[0]), 64'd0);
        chk("occ_turn",    0, 64'(trn[0]), 64'd2);
        chk("occ_count",   0, cnt_v[0],    64'd1);
        chk("occ_board",   0, brd_v[0],    64'h100);
        @(negedge clk);
        chk("occ_pulse1",  0, 64'(ill[0]), 64'd0);
        play(0, 3, 0);
        @(negedge clk);
        chk("oob_illegal", 0, 64'(ill[0]), 64'd1);
        chk("oob_count",   0, cnt_v[0],    64'd1);
        chk("oob_turn",    0, 64'(trn[0]), 64'd2);

        // draw on the 3x3 core
        pulse_start();
        play(0, 0, 0); play(0, 0, 1); play(0, 0, 2); play(0, 1, 1); play(0, 1, 0);
        play(0, 1, 2); play(0, 2, 1); play(0, 2, 0); play(0, 2, 2);
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("draw_flag",   0, 64'(drw[0]), 64'd1);
        chk("draw_winner", 0, 64'(wnr[0]), 64'd0);
        chk("draw_count",  0, cnt_v[0],    64'd9);
        chk("draw_over",   0, 64'(ovr[0]), 64'd1);

        // anti-diagonal completed in the middle on the 5x5 cores
        pulse_start();
        play(2, 0, 3); play(2, 4, 4); play(2, 1, 2); play(2, 4, 3);
        play(2, 3, 0); play(2, 4, 1); play(2, 2, 1);
        repeat (23) @(posedge clk);
        @(negedge clk);
        chk("k4_busy23",   1, 64'(bsy[1]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("k4_winner",   1, 64'(wnr[1]), 64'd1);
        chk("k4_over",     1, 64'(ovr[1]), 64'd1);
        chk("k5_busy24",   2, 64'(bsy[2]), 64'd1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("k5_winner",   2, 64'(wnr[2]), 64'd0);
        chk("k5_over",     2, 64'(ovr[2]), 64'd0);
        chk("k5_turn",     2, 64'(trn[2]), 64'd2);
        chk("k5_ready",    2, 64'(rdy[2]), 64'd1);
        chk("k5_count",    2, cnt_v[2],    64'd7);

        // start aborts a scan
        pulse_start();
        play(0, 0, 0);
        repeat (3) @(negedge clk);
        chk("abort_busy",  0, 64'(bsy[0]), 64'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("abort_board", 0, brd_v[0],    64'd0);
        chk("abort_count", 0, cnt_v[0],    64'd0);
        chk("abort_turn",  0, 64'(trn[0]), 64'd1);
        chk("abort_busy0", 0, 64'(bsy[0]), 64'd0);

        // start beats a same-cycle handshake
        start = 1'b1; move_valid = 1'b1; move_row = 3'd2; move_col = 3'd2;
        @(posedge clk);
        #1 begin start = 1'b0; move_valid = 1'b0; end
        @(negedge clk);
        chk("sthk_ok",     0, 64'(okp[0]), 64'd0);
        chk("sthk_count",  0, cnt_v[0],    64'd0);
        chk("sthk_board",  0, brd_v[0],    64'd0);

        // reset mid-game, together with start
        play(0, 1, 1);
        @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 begin reset = 1'b0; start = 1'b0; end
        @(negedge clk);
        chk("mrst_ready",  0, 64'(rdy[0]), 64'd0);
        chk("mrst_turn",   0, 64'(trn[0]), 64'd0);
        chk("mrst_board",  0, brd_v[0],    64'd0);
        chk("mrst_count",  0, cnt_v[0],    64'd0);
        chk("mrst_busy",   0, 64'(bsy[0]), 64'd0);
        chk("mrst_over",   0, 64'(ovr[0]), 64'd0);
        chk("mrst_winner", 0, 64'(wnr[0]), 64'd0);
        chk("mrst_draw",   0, 64'(drw[0]), 64'd0);
        chk("mrst_ok",     0, 64'(okp[0]), 64'd0);
        chk("mrst_ill",    0, 64'(ill[0]), 64'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
